// File: rtl/imm_extend_pipe.sv
// Immediate extender feeding a 2-entry in-order output buffer.
// Decodes the immediate in the accept cycle and presents it one cycle later; there is no bypass.
module imm_extend_pipe #(
  parameter int DATA_W  = 64,
  parameter int BR_SHL2 = 0
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [25:0]       in_instr,
  input  logic [2:0]        in_ctrl,
  input  logic [DATA_W-1:0] in_keep,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_err,
  output logic              err_sticky,
  input  logic              err_clr
);

  // Handshake: an item moves on a rising edge only when its valid and ready are both 1;
  // valid never waits on ready, and a held head keeps out_imm/out_err stable until taken.

  logic [63:0]       keep_w;
  logic [63:0]       movz_w;
  logic [63:0]       mask_w;
  logic [63:0]       ext_w;
  logic [1:0]        hw;
  logic              illegal;
  logic [DATA_W-1:0] new_imm;
  logic              new_err;

  always_comb begin
    keep_w  = 64'(in_keep);
    hw      = in_instr[22:21];
    movz_w  = 64'(in_instr[20:5]) << {hw, 4'b0000};
    mask_w  = 64'h0000_0000_0000_FFFF << {hw, 4'b0000};
    ext_w   = '0;
    illegal = 1'b0;
    case (in_ctrl)
      3'b000:  ext_w = 64'(in_instr[21:10]);
      3'b001:  ext_w = {{55{in_instr[20]}}, in_instr[20:12]};
      3'b010:  ext_w = {{38{in_instr[25]}}, in_instr[25:0]};
      3'b011:  ext_w = {{45{in_instr[23]}}, in_instr[23:5]};
      3'b100:  ext_w = movz_w;
      3'b101:  ext_w = (keep_w & ~mask_w) | movz_w;
      3'b110:  ext_w = ~movz_w;
      default: illegal = 1'b1;
    endcase
    if (BR_SHL2 != 0 && (in_ctrl == 3'b010 || in_ctrl == 3'b011)) begin
      ext_w = ext_w << 2;
    end
    // A 32-bit result has no halfwords 2 and 3 to move into.
    if (DATA_W == 32 && in_ctrl[2] && in_ctrl != 3'b111 && hw[1]) begin
      illegal = 1'b1;
    end
    if (illegal) begin
      ext_w = '0;
    end
  end

  assign new_imm = ext_w[DATA_W-1:0];
  assign new_err = illegal;

  logic [1:0]        cnt_q,    cnt_d;
  logic [DATA_W-1:0] imm0_q,   imm0_d;
  logic [DATA_W-1:0] imm1_q,   imm1_d;
  logic              err0_q,   err0_d;
  logic              err1_q,   err1_d;
  logic              sticky_q, sticky_d;
  logic              push;
  logic              pop;

  assign in_ready   = resetl & (cnt_q < 2'd2);
  assign out_valid  = (cnt_q != 2'd0);
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign out_imm    = out_valid ? imm0_q : '0;
  assign out_err    = out_valid & err0_q;
  assign err_sticky = sticky_q;

  // Slot 0 is always the head; slot 1 only ever holds the second-oldest item.
  always_comb begin
    cnt_d  = cnt_q;
    imm0_d = imm0_q;
    imm1_d = imm1_q;
    err0_d = err0_q;
    err1_d = err1_q;
    case ({push, pop})
      2'b10: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd0) begin
          imm0_d = new_imm;
          err0_d = new_err;
        end else begin
          imm1_d = new_imm;
          err1_d = new_err;
        end
      end
      2'b01: begin
        cnt_d  = cnt_q - 2'd1;
        imm0_d = imm1_q;
        err0_d = err1_q;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          imm0_d = new_imm;
          err0_d = new_err;
        end else begin
          imm0_d = imm1_q;
          err0_d = err1_q;
          imm1_d = new_imm;
          err1_d = new_err;
        end
      end
      default: ;
    endcase
    sticky_d = sticky_q;
    if (err_clr) begin
      sticky_d = 1'b0;
    end
    if (push && new_err) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      cnt_q    <= 2'd0;
      imm0_q   <= '0;
      imm1_q   <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      imm0_q   <= imm0_d;
      imm1_q   <= imm1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning the output immediate width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter BR_SHL2, default 0, meaning when 1 the B and CB immediates are shifted left by 2 after extension.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port resetl, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an input item is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an item this cycle.
REQ-007 The block SHALL have port in_instr, input, 26 bits: instruction bits [25:0].
REQ-008 The block SHALL have port in_ctrl, input, 3 bits: the extension mode.
REQ-009 The block SHALL have port in_keep, input, DATA_W bits: the prior register value, used by MOVK only.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the head item is presented.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the head item.
REQ-012 The block SHALL have port out_imm, output, DATA_W bits: the extended immediate of the head item.
REQ-013 The block SHALL have port out_err, output, 1 bit: the head item had an illegal mode.
REQ-014 The block SHALL have port err_sticky, output, 1 bit: at least one illegal item has been accepted since reset or clear.
REQ-015 The block SHALL have port err_clr, input, 1 bit: synchronous clear of err_sticky.

Function
REQ-016 An item SHALL be accepted on a rising edge where in_valid and in_ready are both 1, and popped on a rising edge where out_valid and out_ready are both 1.
REQ-017 The extended value SHALL be computed combinationally from in_instr, in_ctrl and in_keep, then stored with its error bit into a 2-entry in-order buffer; latency from accept to out_valid SHALL be 1 cycle.
REQ-018 Mode 000 (I) SHALL zero-extend instr[21:10].
REQ-019 Mode 001 (D) SHALL sign-extend instr[20:12].
REQ-020 Mode 010 (B) SHALL sign-extend instr[25:0], then shift left 2 if BR_SHL2 is 1.
REQ-021 Mode 011 (CB) SHALL sign-extend instr[23:5], then shift left 2 if BR_SHL2 is 1.
REQ-022 Mode 100 (MOVZ) SHALL place instr[20:5] at bit 16*hw, where hw is instr[22:21], with zeros elsewhere.
REQ-023 Mode 101 (MOVK) SHALL output in_keep with bits [16*hw+15:16*hw] replaced by instr[20:5].
REQ-024 Mode 110 (MOVN) SHALL output the bitwise inverse of the MOVZ result.
REQ-025 Mode 111, and any MOV mode with hw of 2 or 3 when DATA_W is 32, SHALL be illegal: the stored immediate is 0 and the stored error bit is 1.
REQ-026 The buffer occupancy SHALL be 0, 1 or 2.
REQ-027 in_ready SHALL equal (occupancy < 2) and SHALL be 0 while resetl is low.
REQ-028 out_valid SHALL equal (occupancy > 0).
REQ-029 When occupancy is 1 and a push and a pop occur on the same edge, occupancy SHALL stay 1 and the new item SHALL become the head.
REQ-030 When occupancy is 0, a push SHALL NOT be presented on out_imm in the same cycle; there is no bypass.
REQ-031 While out_valid is 1 and out_ready is 0, out_imm and out_err SHALL hold stable.
REQ-032 Items SHALL exit in acceptance order with no loss and no duplication.
REQ-033 err_sticky SHALL be set on acceptance of an illegal item and cleared by err_clr; if both occur on the same edge, the set SHALL win.
REQ-034 out_imm and out_err SHALL read 0 whenever out_valid is 0.

Reset
REQ-035 On resetl falling, regardless of CLK, occupancy SHALL become 0 and out_valid, out_imm, out_err and err_sticky SHALL become 0.
REQ-036 Items held at reset SHALL be discarded; after resetl rises, the first rising edge SHALL be able to accept an item.

Verification
REQ-037 D mode, instr[20:12]=9'h1F0, DATA_W=64 -> out_imm 64'hFFFF_FFFF_FFFF_FFF0 one cycle after accept, out_err 0.
REQ-038 MOVK, hw=01, instr[20:5]=16'hBEEF, in_keep=64'h1111_2222_3333_4444 -> out_imm 64'h1111_2222_BEEF_4444.
REQ-039 B mode, BR_SHL2=1, instr=26'h3FFFFFF -> out_imm 64'hFFFF_FFFF_FFFF_FFFC; with BR_SHL2=0 -> 64'hFFFF_FFFF_FFFF_FFFF.
REQ-040 Offer items A, B, C back-to-back with out_ready=0 -> in_ready drops after B and C is held off; raise out_ready -> A, B, C are emitted in order, one per cycle.
REQ-041 ctrl=111 -> out_err 1, out_imm 0, err_sticky 1; pulse err_clr -> err_sticky 0; DATA_W=32 with MOVZ hw=10 -> out_err 1.
REQ-042 Occupancy 2, pull resetl low mid-cycle -> out_valid and err_sticky go 0 before the next edge; after release, a new item is accepted and emitted normally.
